// File: rtl/extra_slot_scheduler.sv
// Arbiter for the spare memory slot (busCycle 2'b10): sound fetches first, then
// round-robin over internal disk, external disk and aux; also drives the slot address and strobes.
module extra_slot_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk8_en_p,
    input  logic [1:0]  busCycle,
    input  logic        dsk_int_req,
    input  logic        dsk_ext_req,
    input  logic        aux_req,
    input  logic [21:0] dsk_int_addr,
    input  logic [21:0] dsk_ext_addr,
    input  logic [21:0] aux_addr,
    input  logic        aux_we,
    input  logic        snd_req,
    input  logic [21:0] snd_addr,
    output logic [3:0]  grant,
    output logic        slot_active,
    output logic [21:0] slot_addr,
    output logic        slot_oe,
    output logic        slot_we,
    output logic [3:0]  done,
    output logic        snd_overrun
);

    // Round-robin index: 0 = dsk_int, 1 = dsk_ext, 2 = aux.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
        logic [1:0] a;
        logic [1:0] b;
        a = rr_next(last);
        b = rr_next(a);
        if (req[a])      return a;
        else if (req[b]) return b;
        else             return rr_next(b);
    endfunction

    function automatic logic [3:0] rr_to_grant(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            default: return 4'b1000;
        endcase
    endfunction

    logic [3:0]  r_grant;
    logic [3:0]  r_done;
    logic [1:0]  r_rr_last;
    logic        r_snd_pending;
    logic        r_snd_overrun;
    logic [21:0] r_snd_addr;

    logic        w_decide;
    logic        w_finish;
    logic        w_snd_done;
    logic [3:0]  w_req;
    logic [1:0]  w_pick;

    assign w_decide   = clk8_en_p && (busCycle == 2'b01);
    assign w_finish   = clk8_en_p && (busCycle == 2'b10) && (|r_grant);
    assign w_snd_done = w_finish && r_grant[2];
    assign w_req      = {1'b0, aux_req, dsk_ext_req, dsk_int_req};
    assign w_pick     = rr_pick(r_rr_last, w_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant       <= '0;
            r_done        <= '0;
            r_rr_last     <= 2'd0;
            r_snd_pending <= 1'b0;
            r_snd_overrun <= 1'b0;
        end else begin
            r_done <= '0;
            if (w_finish) begin
                r_done  <= r_grant;
                r_grant <= '0;
            end else if (w_decide) begin
                // A sound pulse arriving on the decision clk is already treated as pending.
                if (r_snd_pending || snd_req) begin
                    r_grant <= 4'b0100;
                end else if (|w_req) begin
                    r_grant   <= rr_to_grant(w_pick);
                    r_rr_last <= w_pick;
                end
            end
            if (snd_req) begin
                r_snd_pending <= 1'b1;
                if (r_snd_pending && !w_snd_done)
                    r_snd_overrun <= 1'b1;
            end else if (w_snd_done) begin
                r_snd_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (snd_req)
            r_snd_addr <= snd_addr;
    end

    always_comb begin
        slot_addr = '0;
        case (r_grant)
            4'b0001: slot_addr = dsk_int_addr + 22'h100000;
            4'b0010: slot_addr = dsk_ext_addr + 22'h200000;
            4'b0100: slot_addr = r_snd_addr;
            4'b1000: slot_addr = aux_addr;
            default: slot_addr = '0;
        endcase
    end

    assign slot_active = (busCycle == 2'b10) && (|r_grant);
    assign slot_we     = slot_active && r_grant[3] && aux_we;
    assign slot_oe     = slot_active && !(r_grant[3] && aux_we);
    assign grant       = r_grant;
    assign done        = r_done;
    assign snd_overrun = r_snd_overrun;

endmodule

// File: doc/extra_slot_scheduler.md
EXTRA_SLOT_SCHEDULER -- requirements
Module: extra_slot_scheduler

Interface
REQ-001 SHALL have port clk, input, 1, system clock (32.5 MHz, four clk per clk8 period).
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port clk8_en_p, input, 1, one-clk strobe at the last clk of each clk8 period.
REQ-004 SHALL have port busCycle, input, 2, memory cycle index; 2'b10 is the extra slot.
REQ-005 SHALL have ports dsk_int_req / dsk_ext_req / aux_req, input, 1 each, level requests held until the matching done.
REQ-006 SHALL have ports dsk_int_addr / dsk_ext_addr / aux_addr, input, 22 each, word addresses.
REQ-007 SHALL have port aux_we, input, 1, aux request is a write when 1.
REQ-008 SHALL have port snd_req, input, 1, one-clk pulse requesting one sound fetch.
REQ-009 SHALL have port snd_addr, input, 22, sound fetch address, sampled with snd_req.
REQ-010 SHALL have port grant, output, 4, one-hot owner of the current/next slot: bit0 dsk_int, bit1 dsk_ext, bit2 snd, bit3 aux.
REQ-011 SHALL have port slot_active, output, 1, busCycle==2'b10 and grant!=0.
REQ-012 SHALL have port slot_addr, output, 22, memory address for the active slot.
REQ-013 SHALL have ports slot_oe / slot_we, output, 1 each, read/write strobes during the active slot.
REQ-014 SHALL have port done, output, 4, one-clk completion pulse per requester, same bit order as grant.
REQ-015 SHALL have port snd_overrun, output, 1, sticky flag: sound request lost.

Function
REQ-016 Decision SHALL occur on clk8_en_p with busCycle==2'b01; grant registered, valid for the whole following busCycle==2'b10.
REQ-017 Priority SHALL be: pending sound first; otherwise round-robin over dsk_int, dsk_ext, aux, starting after the last non-sound grantee.
REQ-018 snd_req SHALL set snd_pending and capture snd_addr; snd_pending clears at that fetch's done.
REQ-019 snd_req while snd_pending already set SHALL set snd_overrun and overwrite the captured address; snd_overrun clears only on reset.
REQ-020 snd_req coincident with the sound done strobe SHALL leave snd_pending set with the new address, no overrun.
REQ-021 No requests at decision time SHALL give grant=0, idle slot, no strobes, round-robin pointer unchanged.
REQ-022 slot_addr SHALL be dsk_int_addr+22'h100000, dsk_ext_addr+22'h200000, captured sound address, or aux_addr per grant; addition wraps modulo 2^22; 0 when idle.
REQ-023 Address SHALL be taken live from the requester throughout the slot; requesters hold address stable until done.
REQ-024 slot_oe SHALL be 1 in an active slot unless grant is aux with aux_we=1; slot_we SHALL be 1 only for an active aux write.
REQ-025 done bit SHALL pulse on clk8_en_p with busCycle==2'b10 for the granted requester; grant clears in the same clk.
REQ-026 A request dropped after grant SHALL still complete its slot and receive done.
REQ-027 A request dropped before the decision point SHALL not be granted.
REQ-028 Exactly zero or one grant bit SHALL be set at any time.
REQ-029 Sound service latency SHALL be at most one full four-cycle memory period after snd_req.

Reset
REQ-030 On reset: grant=0, done=0, slot_active=0, slot_oe=0, slot_we=0, slot_addr=0, snd_pending=0, snd_overrun=0, round-robin pointer=dsk_int-last (dsk_ext first).
REQ-031 Reset during an active slot SHALL abort it immediately with no done pulse.

Verification
REQ-032 dsk_int_req and dsk_ext_req held, dsk_int_addr=22'h000010 -> grants alternate ext,int,ext,...; int slot_addr=22'h100010.
REQ-033 snd_req pulse with snd_addr=22'h3FFD00 while all disk/aux requests held -> next slot grant=4'b0100, slot_addr=22'h3FFD00, done[2] pulses once.
REQ-034 two snd_req pulses before the first sound slot -> snd_overrun=1, single sound slot using the second address.
REQ-035 aux_req with aux_we=1, aux_addr=22'h012345 -> slot_we=1, slot_oe=0, slot_addr=22'h012345, done[3] pulses.
REQ-036 no requests for 8 periods -> grant=0, no strobes; then reset asserted mid-slot -> all outputs 0, no done.
